// File: rtl/blkmem_port_arbiter.sv
// rtl/blkmem_port_arbiter.sv - port-B arbiter for the shared block RAM (CPU data port vs UART loader)
// One grant per cycle; read data is steered back to its issuer one cycle later.
module blkmem_port_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          boot_mode,
  input  logic          c_req,
  input  logic [3:0]    c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_din,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic [3:0]    l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_din,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic [3:0]    m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_din,
  input  logic [DW-1:0] m_dout
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

  owner_t     last_gnt;
  logic [3:0] wait_cnt;
  logic       rd_pend_v;
  owner_t     rd_pend_own;
  logic       cpu_wins;

  // Conflict resolution: loader priority with a starvation escape in boot mode,
  // otherwise alternate away from whoever was granted last.
  always_comb begin
    cpu_wins = 1'b0;
    if (c_req && l_req) begin
      if (boot_mode) cpu_wins = (wait_cnt == WAIT_LIM);
      else           cpu_wins = (last_gnt == OWN_LDR);
    end else begin
      cpu_wins = c_req;
    end
  end

  assign c_gnt = !Rst && c_req && cpu_wins;
  assign l_gnt = !Rst && l_req && !cpu_wins;

  always_comb begin
    m_en   = 1'b0;
    m_we   = 4'b0;
    m_addr = '0;
    m_din  = '0;
    if (c_gnt) begin
      m_en   = 1'b1;
      m_we   = c_we;
      m_addr = c_addr;
      m_din  = c_din;
    end else if (l_gnt) begin
      m_en   = 1'b1;
      m_we   = l_we;
      m_addr = l_addr;
      m_din  = l_din;
    end
  end

  // A pending tag captured just before reset must not surface during reset.
  assign c_rvalid = !Rst && rd_pend_v && (rd_pend_own == OWN_CPU);
  assign l_rvalid = !Rst && rd_pend_v && (rd_pend_own == OWN_LDR);
  assign c_rdata  = c_rvalid ? m_dout : '0;
  assign l_rdata  = l_rvalid ? m_dout : '0;

  always_ff @(posedge clk) begin
    if (Rst) begin
      last_gnt    <= OWN_LDR;
      wait_cnt    <= 4'd0;
      rd_pend_v   <= 1'b0;
      rd_pend_own <= OWN_CPU;
    end else begin
      if (c_gnt)      last_gnt <= OWN_CPU;
      else if (l_gnt) last_gnt <= OWN_LDR;

      if (c_req && !c_gnt) begin
        if (wait_cnt < WAIT_LIM) wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= 4'd0;
      end

      rd_pend_v   <= m_en && (m_we == 4'b0);
      rd_pend_own <= l_gnt ? OWN_LDR : OWN_CPU;
    end
  end

endmodule

// File: tb/tb_blkmem_port_arbiter.sv
// tb/tb_blkmem_port_arbiter.sv - bench for blkmem_port_arbiter
// Directed vector table followed by constrained-random traffic against a reference model.
module tb_blkmem_port_arbiter;

  localparam int AW       = 11;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << AW;

  logic          clk;
  logic          rst;
  logic          boot_mode;
  logic          c_req, l_req;
  logic [3:0]    c_we, l_we;
  logic [AW-1:0] c_addr, l_addr;
  logic [DW-1:0] c_din, l_din;
  logic          c_gnt, l_gnt, c_rvalid, l_rvalid;
  logic [DW-1:0] c_rdata, l_rdata;
  logic          m_en;
  logic [3:0]    m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_dout;

  int errors;
  int checks;

  blkmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .Rst(rst), .boot_mode(boot_mode),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_din(c_din),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_din(l_din),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Block RAM driven by the DUT's port B.
  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (m_en) begin
      for (int b = 0; b < 4; b++)
        if (m_we[b]) ram[m_addr][8*b +: 8] <= m_din[8*b +: 8];
      if (m_we == 4'b0) m_dout <= ram[m_addr];
    end
  end

  // Reference model state.
  logic [DW-1:0] refmem [0:DEPTH-1];
  bit            mdl_last_ldr;
  int            mdl_wait;
  bit            mdl_pend;
  bit            mdl_pend_ldr;
  logic [DW-1:0] mdl_pend_data;
  bit            c_hold, l_hold;

  typedef struct packed {
    logic          rst, bm, creq;
    logic [3:0]    cwe;
    logic [AW-1:0] caddr;
    logic          lreq;
    logic [3:0]    lwe;
    logic [AW-1:0] laddr;
    logic [DW-1:0] ldin;
    logic          ecg, elg, ecrv;
    logic [DW-1:0] ecrd;
    logic          elrv;
    logic [DW-1:0] elrd;
    logic          emen;
    logic [3:0]    emwe;
    logic [AW-1:0] emaddr;
    logic [DW-1:0] emdin;
  } vec_t;

  vec_t tab [25];

  function automatic vec_t mk(
    logic r, logic bm, logic cq, logic [3:0] cw, logic [AW-1:0] ca,
    logic lq, logic [3:0] lw, logic [AW-1:0] la, logic [DW-1:0] ld,
    logic ecg, logic elg, logic ecrv, logic [DW-1:0] ecrd, logic elrv, logic [DW-1:0] elrd,
    logic emen, logic [3:0] emwe, logic [AW-1:0] emaddr, logic [DW-1:0] emdin);
    vec_t v;
    v.rst = r; v.bm = bm; v.creq = cq; v.cwe = cw; v.caddr = ca;
    v.lreq = lq; v.lwe = lw; v.laddr = la; v.ldin = ld;
    v.ecg = ecg; v.elg = elg; v.ecrv = ecrv; v.ecrd = ecrd; v.elrv = elrv; v.elrd = elrd;
    v.emen = emen; v.emwe = emwe; v.emaddr = emaddr; v.emdin = emdin;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Checks one cycle at the falling edge, advances the model, then moves to posedge+1.
  task automatic step(input bit from_tab, input vec_t v);
    bit            gc, gl;
    logic [3:0]    we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            ecrv, elrv;
    logic [DW-1:0] ecrd, elrd;
    #4;
    gc = !rst && c_req && (!l_req || (boot_mode ? (mdl_wait >= MAX_WAIT) : mdl_last_ldr));
    gl = !rst && l_req && !gc;
    we = gc ? c_we : (gl ? l_we : 4'b0);
    a  = gc ? c_addr : (gl ? l_addr : '0);
    d  = gc ? c_din : (gl ? l_din : '0);
    ecrv = !rst && mdl_pend && !mdl_pend_ldr;
    elrv = !rst && mdl_pend && mdl_pend_ldr;
    ecrd = ecrv ? mdl_pend_data : '0;
    elrd = elrv ? mdl_pend_data : '0;
    if (from_tab) begin
      chk("c_gnt", c_gnt, v.ecg);
      chk("l_gnt", l_gnt, v.elg);
      chk("c_rvalid", c_rvalid, v.ecrv);
      chk("c_rdata", c_rdata, v.ecrd);
      chk("l_rvalid", l_rvalid, v.elrv);
      chk("l_rdata", l_rdata, v.elrd);
      chk("m_en", m_en, v.emen);
      chk("m_we", m_we, v.emwe);
      chk("m_addr", m_addr, v.emaddr);
      chk("m_din", m_din, v.emdin);
    end else begin
      chk("rnd_c_gnt", c_gnt, gc);
      chk("rnd_l_gnt", l_gnt, gl);
      chk("rnd_c_rvalid", c_rvalid, ecrv);
      chk("rnd_c_rdata", c_rdata, ecrd);
      chk("rnd_l_rvalid", l_rvalid, elrv);
      chk("rnd_l_rdata", l_rdata, elrd);
      chk("rnd_m_en", m_en, gc | gl);
      chk("rnd_m_we", m_we, we);
      chk("rnd_m_addr", m_addr, a);
      chk("rnd_m_din", m_din, d);
    end
    if (rst) begin
      mdl_last_ldr = 1'b1;
      mdl_wait     = 0;
      mdl_pend     = 1'b0;
    end else begin
      mdl_pend      = (gc || gl) && (we == 4'b0);
      mdl_pend_ldr  = gl;
      mdl_pend_data = refmem[a];
      for (int b = 0; b < 4; b++)
        if ((gc || gl) && we[b]) refmem[a][8*b +: 8] = d[8*b +: 8];
      if (gc) mdl_last_ldr = 1'b0;
      else if (gl) mdl_last_ldr = 1'b1;
      if (c_req && !gc) mdl_wait = (mdl_wait < MAX_WAIT) ? mdl_wait + 1 : MAX_WAIT;
      else mdl_wait = 0;
    end
    c_hold = c_req && !gc;
    l_hold = l_req && !gl;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input vec_t v);
    rst = v.rst; boot_mode = v.bm;
    c_req = v.creq; c_we = v.cwe; c_addr = v.caddr; c_din = '0;
    l_req = v.lreq; l_we = v.lwe; l_addr = v.laddr; l_din = v.ldin;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return AW'(DEPTH - 1);
      1:       return AW'($urandom_range(0, 3));
      default: return AW'($urandom);
    endcase
  endfunction

  task automatic gen_random();
    rst = ($urandom_range(0, 63) == 0);
    if ($urandom_range(0, 31) == 0) boot_mode = ~boot_mode;
    if (c_hold) begin
      c_req = ($urandom_range(0, 7) != 0);
    end else begin
      c_req  = ($urandom_range(0, 3) != 0);
      c_we   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      c_addr = pick_addr();
      c_din  = $urandom;
    end
    if (l_hold) begin
      l_req = ($urandom_range(0, 7) != 0);
    end else begin
      l_req  = ($urandom_range(0, 3) != 0);
      l_we   = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0;
      l_addr = pick_addr();
      l_din  = $urandom;
    end
  endtask

  localparam logic [DW-1:0] DEAD = 32'hDEADBEEF;
  localparam logic [DW-1:0] CAFE = 32'hCAFEF00D;
  localparam logic [AW-1:0] TOP  = 11'h7FF;

  initial begin
    vec_t none;
    errors = 0;
    checks = 0;
    none = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = {16'(i), 16'hA5C3};
      refmem[i] = {16'(i), 16'hA5C3};
    end
    ram[5] = DEAD;    refmem[5] = DEAD;
    ram[TOP] = CAFE;  refmem[TOP] = CAFE;
    m_dout = '0;
    mdl_last_ldr = 1'b1; mdl_wait = 0; mdl_pend = 1'b0; mdl_pend_ldr = 1'b0; mdl_pend_data = '0;
    c_hold = 1'b0; l_hold = 1'b0;

    //          rst bm cq cwe  caddr lq lwe    laddr ldin          cg lg crv crd          lrv lrd   en we     addr emdin
    tab[0]  = mk(1, 0, 1, 4'h0, 5,   1, 4'h0,   TOP, 0,            0, 0, 0, 0,            0, 0,    0, 4'h0,   0,   0);
    tab[1]  = mk(0, 0, 1, 4'h0, 5,   0, 4'h0,   0,   0,            1, 0, 0, 0,            0, 0,    1, 4'h0,   5,   0);
    tab[2]  = mk(0, 0, 0, 4'h0, 0,   0, 4'h0,   0,   0,            0, 0, 1, DEAD,         0, 0,    0, 4'h0,   0,   0);
    tab[3]  = mk(1, 0, 0, 4'h0, 0,   0, 4'h0,   0,   0,            0, 0, 0, 0,            0, 0,    0, 4'h0,   0,   0);
    tab[4]  = mk(0, 0, 1, 4'h0, 5,   1, 4'h0,   TOP, 0,            1, 0, 0, 0,            0, 0,    1, 4'h0,   5,   0);
    tab[5]  = mk(0, 0, 1, 4'h0, 5,   1, 4'h0,   TOP, 0,            0, 1, 1, DEAD,         0, 0,    1, 4'h0,   TOP, 0);
    tab[6]  = mk(0, 0, 1, 4'h0, 5,   1, 4'h0,   TOP, 0,            1, 0, 0, 0,            1, CAFE, 1, 4'h0,   5,   0);
    tab[7]  = mk(0, 0, 1, 4'h0, 5,   1, 4'h0,   TOP, 0,            0, 1, 1, DEAD,         0, 0,    1, 4'h0,   TOP, 0);
    tab[8]  = mk(0, 0, 0, 4'h0, 0,   0, 4'h0,   0,   0,            0, 0, 0, 0,            1, CAFE, 0, 4'h0,   0,   0);
    tab[9]  = mk(0, 0, 0, 4'h0, 0,   0, 4'h0,   0,   0,            0, 0, 0, 0,            0, 0,    0, 4'h0,   0,   0);
    tab[10] = mk(0, 0, 0, 4'h0, 0,   0, 4'h0,   0,   0,            0, 0, 0, 0,            0, 0,    0, 4'h0,   0,   0);
    tab[11] = mk(0, 0, 1, 4'h0, 5,   1, 4'h0,   TOP, 0,            1, 0, 0, 0,            0, 0,    1, 4'h0,   5,   0);
    tab[12] = mk(0, 1, 1, 4'h0, 5,   1, 4'h0,   TOP, 0,            0, 1, 1, DEAD,         0, 0,    1, 4'h0,   TOP, 0);
    tab[13] = mk(0, 1, 1, 4'h0, 5,   1, 4'h0,   TOP, 0,            0, 1, 0, 0,            1, CAFE, 1, 4'h0,   TOP, 0);
    tab[14] = mk(0, 1, 1, 4'h0, 5,   1, 4'h0,   TOP, 0,            0, 1, 0, 0,            1, CAFE, 1, 4'h0,   TOP, 0);
    tab[15] = mk(0, 1, 1, 4'h0, 5,   1, 4'h0,   TOP, 0,            0, 1, 0, 0,            1, CAFE, 1, 4'h0,   TOP, 0);
    tab[16] = mk(0, 1, 1, 4'h0, 5,   1, 4'h0,   TOP, 0,            1, 0, 0, 0,            1, CAFE, 1, 4'h0,   5,   0);
    tab[17] = mk(0, 0, 0, 4'h0, 0,   0, 4'h0,   0,   0,            0, 0, 1, DEAD,         0, 0,    0, 4'h0,   0,   0);
    tab[18] = mk(0, 0, 0, 4'h0, 0,   1, 4'b0011, TOP, 32'h12345678, 0, 1, 0, 0,           0, 0,    1, 4'b0011, TOP, 32'h12345678);
    tab[19] = mk(0, 0, 1, 4'h0, TOP, 0, 4'h0,   0,   0,            1, 0, 0, 0,            0, 0,    1, 4'h0,   TOP, 0);
    tab[20] = mk(0, 0, 0, 4'h0, 0,   0, 4'h0,   0,   0,            0, 0, 1, 32'hCAFE5678, 0, 0,    0, 4'h0,   0,   0);
    tab[21] = mk(0, 0, 1, 4'h0, 5,   0, 4'h0,   0,   0,            1, 0, 0, 0,            0, 0,    1, 4'h0,   5,   0);
    tab[22] = mk(1, 0, 1, 4'h0, 5,   1, 4'h0,   TOP, 0,            0, 0, 0, 0,            0, 0,    0, 4'h0,   0,   0);
    tab[23] = mk(0, 0, 1, 4'h0, 5,   1, 4'h0,   TOP, 0,            1, 0, 0, 0,            0, 0,    1, 4'h0,   5,   0);
    tab[24] = mk(0, 0, 0, 4'h0, 0,   0, 4'h0,   0,   0,            0, 0, 1, DEAD,         0, 0,    0, 4'h0,   0,   0);

    drive_vec(tab[0]);
    @(posedge clk);
    #1;
    for (int i = 0; i < 25; i++) begin
      drive_vec(tab[i]);
      step(1'b1, tab[i]);
    end

    for (int i = 0; i < 3000; i++) begin
      gen_random();
      step(1'b0, none);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blkmem_port_arbiter.md
# blkmem_port_arbiter

Arbitrates port B of the shared instruction/data block RAM between two requesters: the CPU data port and the UART program loader, which writes program images into shared memory. Each requester uses a req/gnt handshake. The block steers exactly one request per cycle onto the RAM port and returns read data to the requester that issued the read. It sits between the memory controller's non-MMIO data path and the block RAM, and adds no latency beyond the RAM's one-cycle read.

## Interface
Parameters:
- AW, 11, word-address width (RAM is 2^AW 32-bit words)
- DW, 32, data width
- MAX_WAIT, 4, CPU starvation limit in consecutive denied cycles (1..15)

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- Rst  in  1  synchronous active-high reset
- boot_mode  in  1  1 = loader has priority (with CPU starvation guard); 0 = round-robin
- c_req  in  1  CPU request; held with fields stable until c_gnt
- c_we  in  4  CPU byte write enables; 0000 = read
- c_addr  in  AW  CPU word address
- c_din  in  DW  CPU write data
- c_gnt  out  1  CPU request accepted this cycle (combinational)
- c_rvalid  out  1  CPU read data valid
- c_rdata  out  DW  CPU read data
- l_req, l_we, l_addr, l_din  in  1/4/AW/DW  loader request, same rules as CPU
- l_gnt, l_rvalid, l_rdata  out  1/1/DW  loader grant and read response
- m_en  out  1  RAM port enable
- m_we  out  4  RAM byte write enables
- m_addr  out  AW  RAM word address
- m_din  out  DW  RAM write data
- m_dout  in  DW  RAM read data, valid one cycle after an enabled read

## Operation
- At most one grant per cycle. c_gnt and l_gnt are never both 1.
- Single requester: granted in the same cycle.
- Both requesting, boot_mode=0: grant the requester not granted most recently (register last_gnt).
- Both requesting, boot_mode=1: grant the loader, unless wait_cnt == MAX_WAIT; in that case grant the CPU.
- wait_cnt (4-bit) increments each cycle c_req=1 and c_gnt=0, saturating at MAX_WAIT. It clears on c_gnt, or when c_req=0.
- On grant, drive the granted requester's fields onto the RAM port: m_en=1, m_we=we, m_addr=addr, m_din=din.
- No grant: m_en=0, m_we=0, m_addr=0, m_din=0.
- Read (granted with we=0): register tag rd_pend (valid + owner). In the next cycle, assert the owner's rvalid with rdata=m_dout.
- Writes produce no rvalid.
- A non-owner's rdata is 0. Any rdata is 0 when its rvalid is low.
- Back-to-back reads are supported at one per cycle. A response and a new grant may occur in the same cycle.
- last_gnt updates only on a grant. It is unchanged in idle cycles.
- A boot_mode change takes effect in the same cycle's arbitration. wait_cnt is not cleared by the change.

## Timing
- Reset values: last_gnt=loader (the first conflict goes to the CPU), wait_cnt=0, rd_pend=0.
- Outputs during reset: c_rvalid=0, l_rvalid=0, m_en=0, m_we=0, all data outputs 0, c_gnt=0, l_gnt=0 (grants are forced low while Rst=1).
- Reset mid-read: a read granted in the cycle before Rst is asserted produces no rvalid.
- Grant-to-rvalid latency: exactly 1 cycle.
- A requester with req=1 and gnt=0 must hold its fields.
- A requester may drop req without a grant. No state is affected except that wait_cnt clears.
- Worst-case CPU wait is MAX_WAIT cycles in boot_mode=1 and 1 cycle in boot_mode=0.
- Address arithmetic: none. Addresses pass through unchanged and there is no wrap logic; the top address 2^AW-1 is legal.

## Test plan
- Reset, then single CPU read at addr 0x005 with RAM holding 0xDEADBEEF: c_gnt in cycle 0, c_rvalid=1 and c_rdata=0xDEADBEEF in cycle 1, l_rvalid=0.
- Both request continuously with boot_mode=0: grants alternate CPU, loader, CPU, loader. The first conflict goes to the CPU. Each read's data returns to its issuer one cycle later.
- boot_mode=1 with both requesting continuously, MAX_WAIT=4: the loader is granted 4 cycles, then the CPU 1 cycle, repeating (pattern L,L,L,L,C).
- Loader writes l_we=0011, l_din=0x12345678 to addr 0x7FF, then the CPU reads 0x7FF: m_we=0011 and m_addr=0x7FF in the write cycle. The read returns the low half as 0x5678, with the upper bytes unchanged from their prior RAM value.
- Rst asserted in the cycle after a granted CPU read: no c_rvalid. All outputs are 0 during reset, and last_gnt=loader after reset.
- Idle (no req) for 3 cycles: m_en=0, m_we=0, no grants, and last_gnt unchanged. The next conflict follows the prior last_gnt.
